// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised valid/ready pipeline register chain with bubble collapsing
//
// Purpose
//   A chain of DEPTH register stages. Each stage holds a WIDTH-bit payload and a
//   valid bit. A beat moves forward whenever the stage ahead of it is empty or
//   is itself moving, so empty stages (bubbles) are squeezed out rather than
//   stalling earlier stages. Downstream back-pressure (out_ready=0) freezes the
//   occupied tail of the chain. A synchronous flush kills every in-flight beat.
//
// Parameters
//   WIDTH    payload width in bits (>=1)
//   DEPTH    number of register stages (>=1)
//   RST_VAL  value loaded into every data stage on reset
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream beat present
//   in_ready   stage 0 can accept a beat this cycle (low while flush is high)
//   in_data    upstream payload
//   flush      synchronous kill of all in-flight beats
//   out_valid  valid bit of the last stage
//   out_ready  downstream accepts this cycle
//   out_data   payload of the last stage (registered, no path from in_data)
//   occupancy  number of valid stages
//
// Optional build macro
//   PIPE_STAGE_REG_PERF_EN adds stall_cnt[31:0] and bubble_cnt[31:0] outputs.
//   stall_cnt counts cycles with out_valid & ~out_ready, bubble_cnt counts
//   cycles with out_valid=0. Both reset on rst, survive flush and wrap.

module pipe_stage_reg #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  bubble_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Stage state. Index DEPTH-1 is the output stage.
  logic [DEPTH-1:0]            v_q;
  logic [DEPTH-1:0]            v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q;
  logic [DEPTH-1:0][WIDTH-1:0] d_d;

  // adv[i]: stage i may take a new beat at the next edge.
  logic [DEPTH-1:0] adv;
  logic             adv_up;
  logic             adv_cur;
  logic             accept;
  logic [OCC_W-1:0] occ;

  // Advance chain, walked from the output stage back to stage 0.
  // adv_up carries "the stage above me frees its slot" down the chain:
  // at the top that is out_ready, below it is 1 when the stage above is
  // empty (a bubble never blocks) or that stage's own advance otherwise.
  always_comb begin
    adv     = '0;
    adv_up  = out_ready;
    adv_cur = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_cur = ~v_q[i] | adv_up;
      adv[i]  = adv_cur;
      adv_up  = v_q[i] ? adv_cur : 1'b1;
    end
  end

  // Depends on out_ready only through the advance chain, never on in_valid,
  // so no combinational loop can form through an upstream handshake.
  assign in_ready = adv[0] & ~flush;
  assign accept   = in_valid & in_ready;

  // Next-state for valid and data. Data only loads when a real beat arrives,
  // so bubbles and flushes leave payload registers untouched.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = accept;
        if (accept) begin
          d_d[0] = in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            d_d[i] = d_q[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      d_q <= {DEPTH{RST_VAL}};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  // Population count of the valid bits; a pure function of flops.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(v_q[i]);
    end
  end

  assign occupancy = occ;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  // Free-running counters; flush deliberately does not touch them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q  + {31'd0, v_q[DEPTH-1] & ~out_ready};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ~v_q[DEPTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - bench for pipe_stage_reg (WIDTH=32, DEPTH=3)

module tb_pipe_stage_reg;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 3;
  localparam logic [31:0] RSTV  = 32'hDEAD_BEEF;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
`ifdef PIPE_STAGE_REG_PERF_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      bubble_cnt;
`endif

  pipe_stage_reg #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RST_VAL(RSTV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of in-flight beats, oldest first, each tagged with its stage.
  typedef struct {
    logic [31:0] data;
    int          pos;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_last  = RSTV;
  logic [31:0] m_stall = '0;
  logic [31:0] m_bub   = '0;

  function automatic bit m_ov();
    return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
  endfunction

  function automatic bit m_in_ready();
    return !flush && ((mq.size() < DEPTH) || out_ready);
  endfunction

  // Predict the state after the coming edge from the inputs held now.
  task automatic model_step();
    int limit;
    bit leave;
    bit acc;
    acc = in_valid && m_in_ready();
    if (m_ov() && !out_ready) m_stall++;
    if (!m_ov()) m_bub++;
    if (flush) begin
      mq.delete();
      return;
    end
    limit = DEPTH;
    leave = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].pos == DEPTH - 1 && out_ready) begin
        leave = 1'b1;
        limit = DEPTH;
      end else begin
        if (mq[i].pos + 1 < limit) begin
          mq[i].pos = mq[i].pos + 1;
          if (mq[i].pos == DEPTH - 1) m_last = mq[i].data;
        end
        limit = mq[i].pos;
      end
    end
    if (leave) void'(mq.pop_front());
    if (acc) mq.push_back('{in_data, 0});
  endtask

  // Per-cycle compare against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        m_last  = RSTV;
        m_stall = '0;
        m_bub   = '0;
      end
      chk("out_valid", out_valid, m_ov());
      chk("out_data",  out_data,  m_last);
      chk("occupancy", occupancy, mq.size());
      chk("in_ready",  in_ready,  m_in_ready());
`ifdef PIPE_STAGE_REG_PERF_EN
      chk("stall_cnt",  stall_cnt,  m_stall);
      chk("bubble_cnt", bubble_cnt, m_bub);
`endif
      if (!rst) model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    chk("lit_rst_ov",  out_valid, 0);
    chk("lit_rst_od",  out_data,  RSTV);
    chk("lit_rst_occ", occupancy, 0);
    chk("lit_rst_ir",  in_ready,  1);
    tick();
    tick();
    rst = 1'b0;

    // Streaming: 1..4 back to back, output on cycles 3..6.
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4);
      in_data  = c + 1;
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        chk("lit_stream_ov", out_valid, 1);
        chk("lit_stream_od", out_data,  c - 2);
      end
      tick();
    end

    // Stall: fill A0,A1,A2, hold out_ready low for 5 cycles, then drain.
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 8);
      in_valid  = (c < 8);
      in_data   = (c < 3) ? 32'hA0 + c : 32'h99;
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        chk("lit_stall_ir",  in_ready,  0);
        chk("lit_stall_od",  out_data,  32'hA0);
        chk("lit_stall_occ", occupancy, 3);
      end
      if (c >= 8 && c <= 10) chk("lit_drain_od", out_data, 32'hA0 + (c - 8));
      if (c == 11) chk("lit_drain_ov", out_valid, 0);
      tick();
    end

    // Bubble collapse followed by flush.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    @(negedge clk); tick();
    in_valid = 1'b0;
    @(negedge clk); tick();
    in_valid = 1'b1; in_data = 32'hB;
    @(negedge clk); tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_bub_occ", occupancy, 2);
    chk("lit_bub_ir",  in_ready,  1);
    tick();
    @(negedge clk);
    chk("lit_bub_occ2", occupancy, 2);
    chk("lit_bub_od",   out_data,  32'hA);
    tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd7;
    @(negedge clk);
    chk("lit_flush_ir", in_ready, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("lit_flush_occ", occupancy, 0);
    chk("lit_flush_ov",  out_valid, 0);
    chk("lit_flush_ir2", in_ready,  1);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("lit_seven_occ", occupancy, 1);
    tick();
    @(negedge clk); tick();
    @(negedge clk);
    chk("lit_seven_ov", out_valid, 1);
    chk("lit_seven_od", out_data,  32'd7);
    tick();

    // Reset asserted mid-stream.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 * (c + 1);
      @(negedge clk);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("lit_mrst_ov",  out_valid, 0);
    chk("lit_mrst_od",  out_data,  RSTV);
    chk("lit_mrst_occ", occupancy, 0);
    tick();
    @(negedge clk);
    chk("lit_mrst_ir", in_ready, 1);
    tick();

    // Counters start from reset: 3 bubbles, 4 stalls, 1 transfer, 2 idle, flush.
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid  = (c == 0);
      in_data   = 32'h5A;
      out_ready = (c >= 7);
      flush     = (c == 10);
      @(negedge clk);
      if (c == 3) chk("lit_perf_od", out_data, 32'h5A);
`ifdef PIPE_STAGE_REG_PERF_EN
      if (c == 10) begin
        chk("lit_stall_cnt",  stall_cnt,  4);
        chk("lit_bubble_cnt", bubble_cnt, 5);
      end
      if (c == 11) begin
        chk("lit_stall_cnt_fl",  stall_cnt,  4);
        chk("lit_bubble_cnt_fl", bubble_cnt, 6);
      end
`endif
      tick();
    end
    flush = 1'b0;
    @(negedge clk);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
